// File: rtl/dp_patgen_if.sv
// Pixel-FIFO read port shared by the pixel source (slave) and the stuffer that
// drains it (master).
interface dp_patgen_if;
  logic [47:0] fifodo;
  logic        fiforden;
  logic        fifoempty;

  modport master (output fiforden, input fifodo, input fifoempty);
  modport slave  (input fiforden, output fifodo, output fifoempty);
endinterface

// File: rtl/dp_patgen.sv
// Synthetic pixel source standing in for the DMA/pixel FIFO: one frame of
// hact x vact pixels per dmastart, served as pixel pairs on the FIFO read port.
module dp_patgen #(
  parameter int CHKLOG = 4
) (
  input  logic             dpclk,
  input  logic             reset,
  input  logic             dmastart,
  input  logic [15:0]      hact,
  input  logic [15:0]      vact,
  input  logic [1:0]       mode,
  dp_patgen_if.slave       fifo
);

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  frame_q, frame_d;
  logic [31:0] prng_q, prng_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] pairs_q, pairs_d;
  logic [15:0] hact_q, hact_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] boff_q, boff_d;
  logic [47:0] fifodo_q, fifodo_d;
  logic        empty_q, empty_d;

  logic [15:0] bar_w_s;
  logic [15:0] boff_a_s, boff1_s, boff_b_s, boff2_s;
  logic [2:0]  bar1_s, bar2_s;
  logic [15:0] x1_s;
  logic        pix1_valid_s;
  logic [23:0] pix0_s, pix1_s;
  logic [31:0] prng_a_s, prng_b_s;
  logic        line_end_s;
  logic        rd_s;
  logic [15:0] half_s;

  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    return s * 32'd1664525 + 32'd1013904223;
  endfunction

  function automatic logic [2:0] bar_inc(input logic [2:0] b);
    return (b == 3'd7) ? 3'd7 : b + 3'd1;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pix_colour(input logic [1:0] m, input logic [15:0] p,
                                             input logic [2:0] bar, input logic chk_y,
                                             input logic fr0);
    case (m)
      2'd0:    return bar_colour(bar);
      2'd1:    return {3{p[7:0]}};
      2'd2:    return (p[CHKLOG] ^ chk_y ^ fr0) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  // State register with synchronous reset
  always_ff @(posedge dpclk) begin
    if (reset) begin
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      frame_q  <= 8'd0;
      prng_q   <= 32'd0;
      mode_q   <= 2'd0;
      pairs_q  <= 32'd0;
      hact_q   <= 16'd0;
      bar_q    <= 3'd0;
      boff_q   <= 16'd0;
      fifodo_q <= 48'd0;
      empty_q  <= 1'b1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      prng_q   <= prng_d;
      mode_q   <= mode_d;
      pairs_q  <= pairs_d;
      hact_q   <= hact_d;
      bar_q    <= bar_d;
      boff_q   <= boff_d;
      fifodo_q <= fifodo_d;
      empty_q  <= empty_d;
    end
  end

  // Pixel generation and next-state logic
  always_comb begin
    // Bar tracking walks offset-within-bar forward for pixels x+1 and x+2
    bar_w_s  = (hact_q[15:3] == 13'd0) ? 16'd1 : {3'd0, hact_q[15:3]};
    boff_a_s = boff_q + 16'd1;
    if (boff_a_s >= bar_w_s) begin
      bar1_s  = bar_inc(bar_q);
      boff1_s = 16'd0;
    end else begin
      bar1_s  = bar_q;
      boff1_s = boff_a_s;
    end
    boff_b_s = boff1_s + 16'd1;
    if (boff_b_s >= bar_w_s) begin
      bar2_s  = bar_inc(bar1_s);
      boff2_s = 16'd0;
    end else begin
      bar2_s  = bar1_s;
      boff2_s = boff_b_s;
    end

    x1_s         = x_q + 16'd1;
    pix1_valid_s = ({1'b0, x_q} + 17'd1) < {1'b0, hact_q};
    pix0_s       = pix_colour(mode_q, x_q, bar_q, y_q[CHKLOG], frame_q[0]);
    if (pix1_valid_s) begin
      pix1_s = pix_colour(mode_q, x1_s, bar1_s, y_q[CHKLOG], frame_q[0]);
    end else begin
      pix1_s = 24'h000000;
    end

    prng_a_s   = lcg_step(prng_q);
    prng_b_s   = lcg_step(prng_a_s);
    line_end_s = ({1'b0, x_q} + 17'd2) >= {1'b0, hact_q};
    rd_s       = fifo.fiforden & ~empty_q & ~dmastart;
    half_s     = {1'b0, hact[15:1]} + {15'd0, hact[0]};

    x_d      = x_q;
    y_d      = y_q;
    frame_d  = frame_q;
    prng_d   = prng_q;
    mode_d   = mode_q;
    pairs_d  = pairs_q;
    hact_d   = hact_q;
    bar_d    = bar_q;
    boff_d   = boff_q;
    fifodo_d = fifodo_q;
    empty_d  = empty_q;

    if (dmastart) begin
      x_d      = 16'd0;
      y_d      = 16'd0;
      prng_d   = 32'd0;
      fifodo_d = 48'd0;
      mode_d   = mode;
      frame_d  = frame_q + 8'd1;
      hact_d   = hact;
      bar_d    = 3'd0;
      boff_d   = 16'd0;
      pairs_d  = {16'd0, half_s} * {16'd0, vact};
      empty_d  = (hact == 16'd0) || (vact == 16'd0);
    end else if (rd_s) begin
      if (mode_q == 2'd3) begin
        fifodo_d = {prng_a_s[23:0], prng_q[23:0]};
        prng_d   = prng_b_s;
      end else begin
        fifodo_d = {pix1_s, pix0_s};
      end
      pairs_d = pairs_q - 32'd1;
      empty_d = (pairs_q == 32'd1);
      if (line_end_s) begin
        x_d    = 16'd0;
        y_d    = y_q + 16'd1;
        bar_d  = 3'd0;
        boff_d = 16'd0;
      end else begin
        x_d    = x_q + 16'd2;
        bar_d  = bar2_s;
        boff_d = boff2_s;
      end
    end else begin
      fifodo_d = fifodo_q;
    end
  end

  assign fifo.fifodo    = fifodo_q;
  assign fifo.fifoempty = empty_q;

endmodule

// File: tb/tb_dp_patgen.sv
// Directed-vector bench for dp_patgen: each task drives one scenario and checks
// the FIFO read port against hand-derived values.
module tb_dp_patgen;
  logic        dpclk = 1'b0;
  logic        reset = 1'b1;
  logic        dmastart = 1'b0;
  logic [15:0] hact = 16'd0;
  logic [15:0] vact = 16'd0;
  logic [1:0]  mode = 2'd0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_frame = 0;

  dp_patgen_if bus();

  dp_patgen #(.CHKLOG(4)) dut (
    .dpclk    (dpclk),
    .reset    (reset),
    .dmastart (dmastart),
    .hact     (hact),
    .vact     (vact),
    .mode     (mode),
    .fifo     (bus.slave)
  );

  always #5 dpclk = ~dpclk;

  task automatic tick();
    @(posedge dpclk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] h, input logic [15:0] v, input logic [1:0] m);
    hact = h;
    vact = v;
    mode = m;
    dmastart = 1'b1;
    tick();
    dmastart = 1'b0;
    exp_frame = (exp_frame + 1) % 256;
  endtask

  task automatic read_one(output logic [47:0] d);
    bus.fiforden = 1'b1;
    tick();
    bus.fiforden = 1'b0;
    d = bus.fifodo;
  endtask

  function automatic logic [23:0] ref_bar(input int p, input int h);
    int w;
    int idx;
    w = h / 8;
    if (w == 0) w = 1;
    idx = p / w;
    if (idx > 7) idx = 7;
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic test_reset();
    logic [47:0] d;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.fifodo !== 48'h0) begin
      n_errors++; $display("FAIL reset_fifodo got %h exp %h", bus.fifodo, 48'h0);
    end
    n_checks++;
    if (bus.fifoempty !== 1'b1) begin
      n_errors++; $display("FAIL reset_empty got %b exp 1", bus.fifoempty);
    end
    repeat (10) read_one(d);
    n_checks++;
    if (d !== 48'h0 || bus.fifoempty !== 1'b1) begin
      n_errors++; $display("FAIL reset_underrun got %h/%b exp %h/1", d, bus.fifoempty, 48'h0);
    end
  endtask

  task automatic test_colour_bars();
    int xx;
    start_frame(16'd640, 16'd2, 2'd0);
    bus.fiforden = 1'b1;
    for (int i = 0; i < 640; i++) begin
      tick();
      xx = (i % 320) * 2;
      if (i == 0 || i == 320 || (i < 320 && xx == 78)) begin
        n_checks++;
        if (bus.fifodo !== 48'hFFFFFF_FFFFFF) begin
          n_errors++; $display("FAIL bars_white i=%0d got %h exp %h", i, bus.fifodo, 48'hFFFFFF_FFFFFF);
        end
      end
      if (i < 320 && xx == 80) begin
        n_checks++;
        if (bus.fifodo !== 48'hFFFF00_FFFF00) begin
          n_errors++; $display("FAIL bars_yellow got %h exp %h", bus.fifodo, 48'hFFFF00_FFFF00);
        end
      end
      if (xx == 638) begin
        n_checks++;
        if (bus.fifodo !== 48'h000000_000000) begin
          n_errors++; $display("FAIL bars_black i=%0d got %h exp %h", i, bus.fifodo, 48'h0);
        end
      end
      if (i == 638 || i == 639) begin
        n_checks++;
        if (bus.fifoempty !== (i == 639)) begin
          n_errors++; $display("FAIL bars_empty i=%0d got %b exp %b", i, bus.fifoempty, (i == 639));
        end
      end
    end
    tick();
    bus.fiforden = 1'b0;
    n_checks++;
    if (bus.fifoempty !== 1'b1 || bus.fifodo !== 48'h0) begin
      n_errors++; $display("FAIL bars_after_end got %h/%b exp %h/1", bus.fifodo, bus.fifoempty, 48'h0);
    end
  endtask

  task automatic test_bar_edges();
    logic [47:0] d;
    logic [47:0] e;
    start_frame(16'd26, 16'd1, 2'd0);
    for (int k = 0; k < 13; k++) begin
      read_one(d);
      e = {ref_bar(2 * k + 1, 26), ref_bar(2 * k, 26)};
      n_checks++;
      if (d !== e) begin
        n_errors++; $display("FAIL bars26 k=%0d got %h exp %h", k, d, e);
      end
    end
    n_checks++;
    if (bus.fifoempty !== 1'b1) begin
      n_errors++; $display("FAIL bars26_empty got %b exp 1", bus.fifoempty);
    end
    start_frame(16'd6, 16'd1, 2'd0);
    for (int k = 0; k < 3; k++) begin
      read_one(d);
      e = {ref_bar(2 * k + 1, 6), ref_bar(2 * k, 6)};
      n_checks++;
      if (d !== e) begin
        n_errors++; $display("FAIL bars6 k=%0d got %h exp %h", k, d, e);
      end
    end
  endtask

  task automatic test_lcg();
    logic [47:0] d;
    logic [31:0] s1, s2, s3;
    s1 = 32'd1013904223;
    s2 = s1 * 32'd1664525 + 32'd1013904223;
    s3 = s2 * 32'd1664525 + 32'd1013904223;
    for (int f = 0; f < 2; f++) begin
      start_frame(16'd16, 16'd1, 2'd3);
      read_one(d);
      n_checks++;
      if (d !== 48'h6EF35F_000000) begin
        n_errors++; $display("FAIL lcg_pair0 f=%0d got %h exp %h", f, d, 48'h6EF35F_000000);
      end
      read_one(d);
      n_checks++;
      if (d !== {s3[23:0], s2[23:0]}) begin
        n_errors++; $display("FAIL lcg_pair1 f=%0d got %h exp %h", f, d, {s3[23:0], s2[23:0]});
      end
    end
  endtask

  task automatic test_odd_hact();
    logic [47:0] d;
    logic [47:0] exp_v [3];
    exp_v[0] = 48'h000001_000000;
    exp_v[1] = 48'h000003_000002;
    exp_v[2] = 48'h000000_040404;
    exp_v[0] = 48'h010101_000000;
    exp_v[1] = 48'h030303_020202;
    start_frame(16'd5, 16'd2, 2'd1);
    for (int k = 0; k < 6; k++) begin
      read_one(d);
      n_checks++;
      if (d !== exp_v[k % 3] || bus.fifoempty !== (k == 5)) begin
        n_errors++; $display("FAIL odd_hact k=%0d got %h/%b exp %h/%b", k, d, bus.fifoempty, exp_v[k % 3], (k == 5));
      end
    end
  endtask

  task automatic test_checker();
    // make the next frame number even so pixel (0,0) starts black
    if (exp_frame % 2 == 0) start_frame(16'd4, 16'd1, 2'd2);
    start_frame(16'd64, 16'd32, 2'd2);
    bus.fiforden = 1'b1;
    for (int i = 0; i <= 512; i++) begin
      tick();
      if (i == 0) begin
        n_checks++;
        if (bus.fifodo !== 48'h0) begin
          n_errors++; $display("FAIL chk_f1_origin got %h exp %h", bus.fifodo, 48'h0);
        end
      end
      if (i == 8 || i == 512) begin
        n_checks++;
        if (bus.fifodo !== 48'hFFFFFF_FFFFFF) begin
          n_errors++; $display("FAIL chk_f1_cell i=%0d got %h exp %h", i, bus.fifodo, 48'hFFFFFF_FFFFFF);
        end
      end
    end
    bus.fiforden = 1'b0;
    start_frame(16'd64, 16'd32, 2'd2);
    bus.fiforden = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i == 0) begin
        n_checks++;
        if (bus.fifodo !== 48'hFFFFFF_FFFFFF) begin
          n_errors++; $display("FAIL chk_f2_origin got %h exp %h", bus.fifodo, 48'hFFFFFF_FFFFFF);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (bus.fifodo !== 48'h0) begin
          n_errors++; $display("FAIL chk_f2_cell got %h exp %h", bus.fifodo, 48'h0);
        end
      end
    end
    bus.fiforden = 1'b0;
  endtask

  task automatic test_restart();
    logic [47:0] d;
    logic [47:0] e;
    logic [7:0]  px;
    start_frame(16'd8, 16'd4, 2'd1);
    repeat (3) read_one(d);
    dmastart = 1'b1;
    bus.fiforden = 1'b1;
    tick();
    dmastart = 1'b0;
    bus.fiforden = 1'b0;
    exp_frame = (exp_frame + 1) % 256;
    n_checks++;
    if (bus.fifodo !== 48'h0 || bus.fifoempty !== 1'b0) begin
      n_errors++; $display("FAIL restart_state got %h/%b exp %h/0", bus.fifodo, bus.fifoempty, 48'h0);
    end
    for (int k = 0; k < 16; k++) begin
      read_one(d);
      px = 8'((k % 4) * 2);
      e = {{3{px + 8'd1}}, {3{px}}};
      n_checks++;
      if (d !== e || bus.fifoempty !== (k == 15)) begin
        n_errors++; $display("FAIL restart_seq k=%0d got %h/%b exp %h/%b", k, d, bus.fifoempty, e, (k == 15));
      end
    end
    read_one(d);
    n_checks++;
    if (d !== 48'h070707_060606 || bus.fifoempty !== 1'b1) begin
      n_errors++; $display("FAIL restart_underrun got %h/%b exp %h/1", d, bus.fifoempty, 48'h070707_060606);
    end
  endtask

  task automatic test_zero_size();
    logic [47:0] d;
    start_frame(16'd0, 16'd5, 2'd1);
    n_checks++;
    if (bus.fifoempty !== 1'b1 || bus.fifodo !== 48'h0) begin
      n_errors++; $display("FAIL zero_hact got %h/%b exp %h/1", bus.fifodo, bus.fifoempty, 48'h0);
    end
    read_one(d);
    n_checks++;
    if (bus.fifoempty !== 1'b1 || d !== 48'h0) begin
      n_errors++; $display("FAIL zero_hact_read got %h/%b exp %h/1", d, bus.fifoempty, 48'h0);
    end
    start_frame(16'd4, 16'd0, 2'd1);
    n_checks++;
    if (bus.fifoempty !== 1'b1) begin
      n_errors++; $display("FAIL zero_vact got %b exp 1", bus.fifoempty);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] d;
    start_frame(16'd8, 16'd4, 2'd1);
    repeat (2) read_one(d);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_frame = 0;
    n_checks++;
    if (bus.fifodo !== 48'h0 || bus.fifoempty !== 1'b1) begin
      n_errors++; $display("FAIL midreset_state got %h/%b exp %h/1", bus.fifodo, bus.fifoempty, 48'h0);
    end
    start_frame(16'd64, 16'd1, 2'd2);
    read_one(d);
    n_checks++;
    if (d !== 48'hFFFFFF_FFFFFF) begin
      n_errors++; $display("FAIL midreset_frame1 got %h exp %h", d, 48'hFFFFFF_FFFFFF);
    end
  endtask

  initial begin
    bus.fiforden = 1'b0;
    test_reset();
    test_colour_bars();
    test_bar_edges();
    test_lcg();
    test_odd_hact();
    test_checker();
    test_restart();
    test_zero_size();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
